// File: rtl/snake_pkg.sv
// Shared snake-game definitions: grid limits, coordinate widths, master-state
// and direction encodings, and the target generator FSM state type.
package snake_pkg;

  localparam int H_W = 8;
  localparam int V_W = 7;

  localparam int unsigned GRID_MAX_X = 159;
  localparam int unsigned GRID_MAX_Y = 119;

  typedef enum logic [1:0] {
    MS_START = 2'd0,
    MS_PLAY  = 2'd1,
    MS_WIN   = 2'd2,
    MS_RSVD  = 2'd3
  } mstate_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    TG_HOLD   = 2'd0,
    TG_SEARCH = 2'd1,
    TG_DONE   = 2'd2
  } tg_state_e;

endpackage

// File: rtl/target_generator_if.sv
// Link between the target generator and its neighbours: master state and
// REACHED pulse in, target position, score and win flag out.
interface target_generator_if;
  import snake_pkg::*;

  logic [1:0]     M_STATE;
  logic           REACHED;
  logic [H_W-1:0] TARGET_H;
  logic [V_W-1:0] TARGET_V;
  logic           TARGET_VALID;
  logic [3:0]     SCORE;
  logic           WIN;

  modport master (
    output M_STATE, REACHED,
    input  TARGET_H, TARGET_V, TARGET_VALID, SCORE, WIN
  );

  modport slave (
    input  M_STATE, REACHED,
    output TARGET_H, TARGET_V, TARGET_VALID, SCORE, WIN
  );

endinterface

// File: rtl/snake_lfsr.sv
// Free-running Fibonacci LFSR; shifts left with the XOR of the masked taps
// entering at bit 0. Reset reloads the seed, which must be nonzero.
module snake_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_q;
  logic             w_fb;

  assign w_fb    = ^(r_q & TAPS);
  assign o_value = r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= SEED;
    end else begin
      r_q <= {r_q[WIDTH-2:0], w_fb};
    end
  end

endmodule

// File: rtl/target_generator.sv
// Places food targets from LFSR candidates and keeps the score.
// Define TARGET_GEN_TIMEOUT_EN to relocate targets left uneaten too long.
module target_generator
  import snake_pkg::*;
#(
  parameter int unsigned    MAX_X     = GRID_MAX_X,
  parameter int unsigned    MAX_Y     = GRID_MAX_Y,
  parameter int unsigned    WIN_SCORE = 10,
  parameter int unsigned    INIT_H    = 40,
  parameter int unsigned    INIT_V    = 30,
  parameter logic [H_W-1:0] SEED_H    = 8'hA5,
  parameter logic [V_W-1:0] SEED_V    = 7'h5B
`ifdef TARGET_GEN_TIMEOUT_EN
  , parameter int unsigned  TIMEOUT_CYCLES = 200000000
`endif
) (
  input logic CLK,
  input logic RESET,
  target_generator_if.slave bus
);

  localparam logic [H_W-1:0] LIM_H    = H_W'(MAX_X);
  localparam logic [V_W-1:0] LIM_V    = V_W'(MAX_Y);
  localparam logic [H_W-1:0] INIT_H_L = H_W'(INIT_H);
  localparam logic [V_W-1:0] INIT_V_L = V_W'(INIT_V);
  localparam logic [3:0]     WIN_LAST = 4'(WIN_SCORE);
`ifdef TARGET_GEN_TIMEOUT_EN
  localparam logic [31:0]    TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
`endif

  tg_state_e      r_state;
  logic [H_W-1:0] r_targetH;
  logic [V_W-1:0] r_targetV;
  logic           r_valid;
  logic [3:0]     r_score;
  logic           r_win;
`ifdef TARGET_GEN_TIMEOUT_EN
  logic [31:0]    r_timer;
`endif

  logic [H_W-1:0] w_lfsrH;
  logic [V_W-1:0] w_lfsrV;
  logic [H_W-1:0] w_candH;
  logic [V_W-1:0] w_candV;
  logic           w_candOk;
  logic           w_play;
  logic [3:0]     w_scoreNext;

  // Taps 8,6,5,4 and 7,6 give maximal periods 255 and 127, which are coprime.
  snake_lfsr #(.WIDTH(H_W), .TAPS(8'hB8), .SEED(SEED_H)) u_lfsrH (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .o_value (w_lfsrH)
  );

  snake_lfsr #(.WIDTH(V_W), .TAPS(7'h60), .SEED(SEED_V)) u_lfsrV (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .o_value (w_lfsrV)
  );

  // An LFSR never holds zero, so subtracting one maps it onto 0-based coordinates.
  assign w_candH     = w_lfsrH - 1'b1;
  assign w_candV     = w_lfsrV - 1'b1;
  assign w_candOk    = (w_candH <= LIM_H) && (w_candV <= LIM_V);
  assign w_play      = (bus.M_STATE == MS_PLAY);
  assign w_scoreNext = r_score + 4'd1;

  assign bus.TARGET_H     = r_targetH;
  assign bus.TARGET_V     = r_targetV;
  assign bus.TARGET_VALID = r_valid;
  assign bus.SCORE        = r_score;
  assign bus.WIN          = r_win;

  // Outside play everything but the LFSRs freezes, so REACHED is ignored there.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= TG_HOLD;
      r_targetH <= INIT_H_L;
      r_targetV <= INIT_V_L;
      r_valid   <= 1'b1;
      r_score   <= 4'd0;
      r_win     <= 1'b0;
`ifdef TARGET_GEN_TIMEOUT_EN
      r_timer   <= '0;
`endif
    end else if (w_play) begin
      case (r_state)
        TG_HOLD: begin
          if (bus.REACHED) begin
            r_score <= w_scoreNext;
            if (w_scoreNext == WIN_LAST) begin
              r_state <= TG_DONE;
              r_win   <= 1'b1;
            end else begin
              r_state <= TG_SEARCH;
              r_valid <= 1'b0;
            end
          end
`ifdef TARGET_GEN_TIMEOUT_EN
          else if (r_timer == TIMEOUT_LAST) begin
            r_state <= TG_SEARCH;
            r_valid <= 1'b0;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
`endif
        end
        TG_SEARCH: begin
          if (w_candOk) begin
            r_targetH <= w_candH;
            r_targetV <= w_candV;
            r_valid   <= 1'b1;
            r_state   <= TG_HOLD;
`ifdef TARGET_GEN_TIMEOUT_EN
            r_timer   <= '0;
`endif
          end
        end
        TG_DONE: begin
        end
        default: begin
          r_state <= TG_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_target_generator.sv
// Randomised bench for target_generator against a transaction-level model.
// Honours TARGET_GEN_TIMEOUT_EN (timeout shortened to 50 cycles).
module tb_target_generator;

  logic clk;
  logic reset;
  int   total;
  int   bad;

`ifdef TARGET_GEN_TIMEOUT_EN
  localparam int TO = 50;
`endif

  target_generator_if bus();

`ifdef TARGET_GEN_TIMEOUT_EN
  target_generator #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );
`else
  target_generator dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: LFSR values, expected outputs and a coarse mode flag.
  int mLfsrH;
  int mLfsrV;
  int mTh;
  int mTv;
  int mValid;
  int mScore;
  int mWin;
  int mMode;
  int mTimer;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int stepH(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v * 2) % 256) + fb;
  endfunction

  function automatic int stepV(input int v);
    int fb;
    fb = ((v >> 6) ^ (v >> 5)) & 1;
    return ((v * 2) % 128) + fb;
  endfunction

  task automatic modelEdge(input bit rst, input int ms, input bit reached);
    int candH;
    int candV;
    if (rst) begin
      mLfsrH = 'hA5; mLfsrV = 'h5B;
      mTh = 40; mTv = 30; mValid = 1; mScore = 0; mWin = 0; mMode = 0; mTimer = 0;
      return;
    end
    candH  = mLfsrH - 1;
    candV  = mLfsrV - 1;
    mLfsrH = stepH(mLfsrH);
    mLfsrV = stepV(mLfsrV);
    if (ms != 1) return;
    if (mMode == 0) begin
      if (reached) begin
        mScore++;
        if (mScore == 10) begin
          mMode = 2; mWin = 1;
        end else begin
          mMode = 1; mValid = 0;
        end
      end
`ifdef TARGET_GEN_TIMEOUT_EN
      else if (mTimer == TO - 1) begin
        mMode = 1; mValid = 0;
      end else begin
        mTimer++;
      end
`endif
    end else if (mMode == 1) begin
      if (candH <= 159 && candV <= 119) begin
        mTh = candH; mTv = candV; mValid = 1; mMode = 0; mTimer = 0;
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, then compare just after it.
  task automatic applyStimulus(input bit rst, input int ms, input bit reached);
    reset       = rst;
    bus.M_STATE = 2'(ms);
    bus.REACHED = reached;
    @(posedge clk);
    modelEdge(rst, ms, reached);
    #1;
    checkOutput("targetH", 32'(bus.TARGET_H), 32'(mTh));
    checkOutput("targetV", 32'(bus.TARGET_V), 32'(mTv));
    checkOutput("valid", 32'(bus.TARGET_VALID), 32'(mValid));
    checkOutput("score", 32'(bus.SCORE), 32'(mScore));
    checkOutput("win", 32'(bus.WIN), 32'(mWin));
    checkOutput("rangeH", 32'(bus.TARGET_H <= 8'd159), 32'd1);
    checkOutput("rangeV", 32'(bus.TARGET_V <= 7'd119), 32'd1);
  endtask

  task automatic waitValid(input int budget);
    int n;
    n = 0;
    while (bus.TARGET_VALID !== 1'b1 && n < budget) begin
      applyStimulus(0, 1, 0);
      n++;
    end
    checkOutput("waitValid", 32'(bus.TARGET_VALID), 32'd1);
  endtask

  task automatic checkResetValues();
    checkOutput("rstH", 32'(bus.TARGET_H), 32'd40);
    checkOutput("rstV", 32'(bus.TARGET_V), 32'd30);
    checkOutput("rstValid", 32'(bus.TARGET_VALID), 32'd1);
    checkOutput("rstScore", 32'(bus.SCORE), 32'd0);
    checkOutput("rstWin", 32'(bus.WIN), 32'd0);
  endtask

  initial begin
    logic [7:0] savedH;
    logic [6:0] savedV;
    int ms;
    int r;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.M_STATE = 2'd0;
    bus.REACHED = 1'b0;

    // Reset values
    repeat (3) applyStimulus(1, 0, 0);
    checkResetValues();

    // First eat: score and valid change on the next cycle
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    checkOutput("eatScore", 32'(bus.SCORE), 32'd1);
    checkOutput("eatValid", 32'(bus.TARGET_VALID), 32'd0);
    waitValid(300);

    // Randomised play with occasional resets and non-play master states
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) ms = 1;
      else if (r == 8) ms = 0;
      else ms = $urandom_range(2, 3);
      applyStimulus($urandom_range(0, 199) == 0, ms, $urandom_range(0, 5) == 0);
    end

    // Ten eats win; an eleventh changes nothing
    applyStimulus(1, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 1, 1);
      checkOutput("winScore", 32'(bus.SCORE), 32'(k));
      waitValid(300);
    end
    checkOutput("winFlag", 32'(bus.WIN), 32'd1);
    savedH = 8'(mTh);
    savedV = 7'(mTv);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0);
    checkOutput("satScore", 32'(bus.SCORE), 32'd10);
    checkOutput("frozenH", 32'(bus.TARGET_H), 32'(savedH));
    checkOutput("frozenV", 32'(bus.TARGET_V), 32'(savedV));

    // REACHED outside play is ignored; reset in the middle of SEARCH
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 2, 1);
    checkResetValues();
    applyStimulus(0, 1, 1);
    checkOutput("searchValid", 32'(bus.TARGET_VALID), 32'd0);
    applyStimulus(1, 1, 0);
    checkResetValues();

`ifdef TARGET_GEN_TIMEOUT_EN
    // Timeout relocation without score change, then REACHED on the last hold cycle
    repeat (TO) applyStimulus(0, 1, 0);
    checkOutput("toValid", 32'(bus.TARGET_VALID), 32'd0);
    checkOutput("toScore", 32'(bus.SCORE), 32'd0);
    waitValid(300);
    repeat (TO - 1) applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    checkOutput("toEatScore", 32'(bus.SCORE), 32'd1);
    waitValid(300);
    applyStimulus(0, 1, 0);
    checkOutput("toSingle", 32'(bus.TARGET_VALID), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
